// File: rtl/tug_press_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// tug_pkg: shared types and default parameters for the tug-of-war button
// front end (tug_press_conditioner).
//
// Contents:
//   press_state_t          debounce FSM state encoding
//   DEBOUNCE_DEFAULT       stable cycles to accept a press/release (1 ms @ 50 MHz)
//   REPEAT_DELAY_DEFAULT   cycles held before the first auto-repeat pulse
//   REPEAT_PERIOD_DEFAULT  cycles between subsequent auto-repeat pulses
// ---------------------------------------------------------------------------
package tug_pkg;

  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    PRESS_CHK   = 2'd1,
    PRESSED     = 2'd2,
    RELEASE_CHK = 2'd3
  } press_state_t;

  localparam int DEBOUNCE_DEFAULT      = 50000;
  localparam int REPEAT_DELAY_DEFAULT  = 25000000;
  localparam int REPEAT_PERIOD_DEFAULT = 5000000;

endpackage

// File: rtl/tug_press_conditioner_if.sv
// ---------------------------------------------------------------------------
// tug_press_conditioner_if: signal bundle between a player's button/game
// logic and the press conditioner.
//
// Signals:
//   key_n   raw active-low button, asynchronous to clk (0 = pressed)
//   enable  1 = press pulses may be emitted, 0 = suppress
//   press   one-cycle pulse per accepted press (registered)
//   held    debounced "button is down" level (registered)
//   state   debounce FSM state, exported for observation
//
// Modports:
//   master  drives key_n/enable, observes press/held/state
//   slave   the conditioner itself
//
// There is no valid/ready handshake on this bundle: key_n and enable are
// plain levels sampled every clock, press is a single-cycle strobe with no
// back-pressure, and held/state are levels.
// ---------------------------------------------------------------------------
interface tug_press_conditioner_if;
  import tug_pkg::*;

  logic         key_n;
  logic         enable;
  logic         press;
  logic         held;
  press_state_t state;

  modport master (
    output key_n,
    output enable,
    input  press,
    input  held,
    input  state
  );

  modport slave (
    input  key_n,
    input  enable,
    output press,
    output held,
    output state
  );

endinterface

// File: rtl/tug_press_conditioner_sync2.sv
// ---------------------------------------------------------------------------
// sync2: generic two-flop synchronizer for signals asynchronous to clk.
//
// Parameters:
//   WIDTH        number of independent bits synchronized
//   RESET_VALUE  value both flop stages take during reset
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   d      asynchronous input
//   q      synchronized output (two clk edges of latency)
// ---------------------------------------------------------------------------
module sync2 #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tug_press_conditioner.sv
// ---------------------------------------------------------------------------
// tug_press_conditioner: turns one player's raw, bouncy, active-low push
// button into a clean one-cycle "press" pulse for the playfield.
//
// Pipeline: two-flop synchronizer (preset to released) -> debounce FSM
// (RELEASED / PRESS_CHK / PRESSED / RELEASE_CHK) -> enable gating.
//
// Optional feature, selected by the macro AUTO_REPEAT_EN: while the button
// stays in PRESSED, emit a repeat pulse after REPEAT_DELAY cycles and then
// every REPEAT_PERIOD cycles. Without the macro the REPEAT_* parameters are
// ignored and exactly one pulse is emitted per press.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles to accept a press or release (>= 1)
//   REPEAT_DELAY     cycles in PRESSED before the first repeat pulse
//   REPEAT_PERIOD    cycles between later repeat pulses
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-low reset
//   io     tug_press_conditioner_if.slave (key_n, enable, press, held, state)
// ---------------------------------------------------------------------------
module tug_press_conditioner
  import tug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  tug_press_conditioner_if.slave  io
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("tug_press_conditioner: DEBOUNCE_CYCLES must be at least 1");
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("tug_press_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be at least 1");
  end

  logic [RPT_W-1:0] rpt;
  // Set while waiting for the first (longer) repeat interval.
  logic             rpt_first;
`endif

  logic         key_sync;
  logic         key_s;
  press_state_t state;
  logic [CNT_W-1:0] cnt;
  logic         press_q;
  logic         held_q;

  // Preset to 1 so that reset looks like a released button; a button held
  // through reset is therefore qualified from scratch as a new press.
  sync2 #(
    .WIDTH       (1),
    .RESET_VALUE (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (io.key_n),
    .q     (key_sync)
  );

  assign key_s = ~key_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RELEASED;
      cnt       <= '0;
      press_q   <= 1'b0;
      held_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt       <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      // press is a strobe: low unless a pulse is issued this edge.
      press_q <= 1'b0;
      unique case (state)
        RELEASED: begin
          if (key_s) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (!key_s) begin
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= PRESSED;
            cnt     <= '0;
            held_q  <= 1'b1;
            // enable only matters at this edge; a suppressed press is lost.
            press_q <= io.enable;
`ifdef AUTO_REPEAT_EN
            rpt       <= '0;
            rpt_first <= 1'b1;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!key_s) begin
            state <= RELEASE_CHK;
            cnt   <= '0;
`ifdef AUTO_REPEAT_EN
            rpt   <= '0;
`endif
          end
`ifdef AUTO_REPEAT_EN
          else if (rpt == (rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST)) begin
            press_q   <= io.enable;
            rpt       <= '0;
            rpt_first <= 1'b0;
          end else begin
            rpt <= rpt + 1'b1;
          end
`endif
        end
        RELEASE_CHK: begin
          if (key_s) begin
            // Bounce back to PRESSED: no pulse, and the full repeat delay
            // starts over.
            state <= PRESSED;
            cnt   <= '0;
`ifdef AUTO_REPEAT_EN
            rpt       <= '0;
            rpt_first <= 1'b1;
`endif
          end else if (cnt == CNT_LAST) begin
            state  <= RELEASED;
            cnt    <= '0;
            held_q <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= RELEASED;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign io.press = press_q;
  assign io.held  = held_q;
  assign io.state = state;

endmodule

// File: tb/tb_tug_press_conditioner.sv
// ---------------------------------------------------------------------------
// tb_tug_press_conditioner: directed bench for tug_press_conditioner with
// DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4. Inputs are changed
// 2 time units after a rising edge; outputs are sampled at the same point,
// so the value seen after tick number n is the register state following
// rising edge n. With DEBOUNCE_CYCLES=4 an accepted press pulses after the
// 7th edge counted from the first edge sampling key_n=0.
// ---------------------------------------------------------------------------
module tb_tug_press_conditioner;
  import tug_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  tug_press_conditioner_if bus ();

  tug_press_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (4)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .io    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected press value k edges after the accept edge while still held
  // (enable assumed high).
  function automatic logic exp_rep(input int k);
`ifdef AUTO_REPEAT_EN
    return (k == 0) || (k >= 8 && ((k - 8) % 4) == 0);
`else
    return k == 0;
`endif
  endfunction

  task automatic release_key(input string tag);
    bus.key_n = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      tick();
      chk(tag, {1'b0, bus.held}, {1'b0, (j < 7)});
    end
    chk({tag, "_state"}, bus.state, RELEASED);
  endtask

  initial begin
    // Reset state
    rst_n      = 1'b0;
    bus.key_n  = 1'b1;
    bus.enable = 1'b1;
    #1;
    chk("reset_press", {1'b0, bus.press}, 2'd0);
    chk("reset_held", {1'b0, bus.held}, 2'd0);
    chk("reset_state", bus.state, RELEASED);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_press", {1'b0, bus.press}, 2'd0);

    // Clean press, 20 cycles low
    bus.key_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("clean_press", {1'b0, bus.press}, {1'b0, (i >= 7) ? exp_rep(i - 7) : 1'b0});
      chk("clean_held", {1'b0, bus.held}, {1'b0, (i >= 7)});
    end
    release_key("clean_release_held");

    // Press bounce: low 3, high 1, low 15
    for (int i = 1; i <= 19; i++) begin
      bus.key_n = (i == 4);
      tick();
      chk("bounce_press", {1'b0, bus.press}, {1'b0, (i >= 11) ? exp_rep(i - 11) : 1'b0});
      chk("bounce_held", {1'b0, bus.held}, {1'b0, (i >= 11)});
    end
    release_key("bounce_release_held");

    // Release bounce: held, then high 2 cycles, then low again
    bus.key_n = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("rbounce_accept", {1'b0, bus.press}, {1'b0, (i == 7)});
    end
    for (int r = 1; r <= 10; r++) begin
      bus.key_n = (r <= 2);
      tick();
      chk("rbounce_held", {1'b0, bus.held}, 2'd1);
      chk("rbounce_press", {1'b0, bus.press}, 2'd0);
    end
    release_key("rbounce_release_held");

    // Enable gating: enable=0 at the accept edge, then raised while held
    bus.enable = 1'b0;
    bus.key_n  = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 11) bus.enable = 1'b1;
      tick();
      chk("gate_press", {1'b0, bus.press},
          {1'b0, (i >= 11) ? exp_rep(i - 7) : 1'b0});
      chk("gate_held", {1'b0, bus.held}, {1'b0, (i >= 7)});
    end
    release_key("gate_release_held");

    // Next press: enable low early in qualification, high at accept edge
    bus.enable = 1'b0;
    bus.key_n  = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      if (i == 5) bus.enable = 1'b1;
      tick();
      chk("midq_press", {1'b0, bus.press}, {1'b0, (i == 7)});
    end
    release_key("midq_release_held");

    // Asynchronous reset while the pulse is showing
    bus.key_n = 1'b0;
    for (int i = 1; i <= 7; i++) tick();
    chk("prereset_press", {1'b0, bus.press}, 2'd1);
    chk("prereset_held", {1'b0, bus.held}, 2'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_reset_press", {1'b0, bus.press}, 2'd0);
    chk("async_reset_held", {1'b0, bus.held}, 2'd0);
    chk("async_reset_state", bus.state, RELEASED);
    tick();
    tick();
    chk("in_reset_held", {1'b0, bus.held}, 2'd0);
    rst_n = 1'b1;
    // Key still low through reset release: qualified as a new press
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("postreset_press", {1'b0, bus.press}, {1'b0, (i == 7)});
      chk("postreset_held", {1'b0, bus.held}, {1'b0, (i >= 7)});
    end
    release_key("postreset_release_held");

    // Long hold: single pulse, or accept+0/+8/+12/+16/+20 with auto-repeat
    bus.key_n = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      chk("hold_press", {1'b0, bus.press}, {1'b0, (i >= 7) ? exp_rep(i - 7) : 1'b0});
    end
    release_key("hold_release_held");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tug_press_conditioner.md
Name: tug_press_conditioner

Overview:
- Front end for one player of the tug-of-war game. Converts a raw, bouncy, active-low push-button (KEY) into a clean one-cycle "press" pulse.
- The pulse drives the playfield's Rin or Lin input. Two instances are used, one per player.
- Internals: two-flop synchronizer, debounce FSM, enable gating. Optional auto-repeat.

Parameters:
- DEBOUNCE_CYCLES, 50000, stable cycles required to accept a press or release (1 ms at 50 MHz); legal range 1 or more.
- REPEAT_DELAY, 25000000, cycles held in PRESSED before the first auto-repeat pulse; used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat pulses; used only with AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- key_n  input  1  raw button, asynchronous to clk; 0 = pressed.
- enable  input  1  1 = pulses may be emitted; 0 = suppress (game in a win state).
- press  output  1  one-cycle pulse per accepted press; registered.
- held  output  1  debounced "button is down" level; registered.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low.
- Reset (reset=0):
  - Synchronizer flops preset to 1 (released).
  - FSM goes to RELEASED, counters clear, press=0, held=0. All take effect immediately, without waiting for a clock edge.
- Synchronizer: key_s = NOT sync2, where sync1 <= key_n and sync2 <= sync1.
- Counter: cnt, width $clog2(DEBOUNCE_CYCLES+1), unsigned; never wraps; cleared on every state change.
- FSM states and transitions:
  - RELEASED: if key_s=1, go to PRESS_CHK with cnt=0.
  - PRESS_CHK:
    - If key_s=0, return to RELEASED (glitch, no pulse).
    - Else if cnt == DEBOUNCE_CYCLES-1, go to PRESSED and register press=enable.
    - Else cnt++.
  - PRESSED: if key_s=0, go to RELEASE_CHK with cnt=0.
  - RELEASE_CHK:
    - If key_s=1, return to PRESSED (bounce, no pulse).
    - Else if cnt == DEBOUNCE_CYCLES-1, go to RELEASED.
    - Else cnt++.
- held = 1 in PRESSED and RELEASE_CHK; registered alongside the state.
- Latency: press is high during the single cycle following rising edge number DEBOUNCE_CYCLES+3, counting from the first edge that samples key_n=0, provided key_n stays low throughout.
- Pulse rules:
  - press is high for exactly one cycle per accepted press.
  - No pulse is ever deferred: enable=0 at the accept edge consumes the press silently, and raising enable later while still held gives no pulse.
- Button held low through reset release: the press is treated as new and is qualified from scratch.
- enable changing mid-qualification: only its value at the accept edge matters.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - Repeat counter rpt, width $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1), clears on entry to PRESSED and counts while in PRESSED.
  - First repeat pulse is emitted when rpt reaches REPEAT_DELAY-1; after that, one pulse every REPEAT_PERIOD cycles.
  - Each repeat pulse is gated by enable in the same way as the initial pulse.
  - Leaving PRESSED for RELEASE_CHK clears rpt. A bounce back into PRESSED restarts the full REPEAT_DELAY.
- Undefined: rpt logic is absent, REPEAT_* parameters are ignored, and exactly one pulse is emitted per press.

Decomposition:
- tug_pkg holds:
  - typedef enum logic [1:0] press_state_t {RELEASED, PRESS_CHK, PRESSED, RELEASE_CHK};
  - localparam defaults: DEBOUNCE_DEFAULT=50000, REPEAT_DELAY_DEFAULT, REPEAT_PERIOD_DEFAULT.
- Sub-module sync2: generic two-flop synchronizer with a reset-value parameter. Instantiated here with reset value 1.

Test Plan (DEBOUNCE_CYCLES=4 unless stated):
- Reset: drive reset=0 mid-hold with press pending -> press=0, held=0 immediately. Release reset with key_n=0 held -> one pulse 7 edges later.
- Clean press: key_n=0 for 20 cycles, enable=1 -> press=1 for exactly one cycle, 7 edges after the first low sample. held=1 from that cycle until 7 edges after key_n returns to 1.
- Press bounce: key_n low 3 cycles, high 1, low 15 -> exactly one pulse, 7 edges after the second falling edge.
- Release bounce: while held, key_n high 2 cycles then low again -> held stays 1, no extra pulse.
- Enable gating: enable=0 at the accept edge -> no pulse, held=1. Raise enable while still held -> no pulse. Next press -> pulse.
- AUTO_REPEAT_EN with REPEAT_DELAY=8, REPEAT_PERIOD=4: hold 30 cycles -> pulses at accept+0, +8, +12, +16, +20. With the macro undefined, the same stimulus gives a single pulse.
